i2c_bus_arbiter: RTL and testbench

- Shares one open-drain I2C channel (SCL/SDA output-enable pair plus pad inputs) between NUM_REQ masters, e.g. the Qsys I2C core and a fabric-side sensor poller.
- Grants the bus round-robin, only when the bus is idle.
- Routes the owner's output enables to the pads.
- Revokes ownership on timeout.
- Sits between the requesters and the top-level tristate assigns, one instance per channel.

---
 rtl/i2c_bus_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_bus_arbiter
// Brief    : Round-robin owner arbitration of one open-drain I2C channel with
//            idle qualification, ownership timeout and optional SCL recovery
//            (enabled by defining I2C_BUS_RECOVERY_EN).
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int IDLE_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int HALF_PERIOD    = 500
) (
    input  logic                       clk_100_clk,
    input  logic                       reset_100_reset,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic [NUM_REQ-1:0]         req_scl_oe,
    input  logic [NUM_REQ-1:0]         req_sda_oe,
    input  logic                       bus_scl_in,
    input  logic                       bus_sda_in,
    output logic                       bus_scl_oe,
    output logic                       bus_sda_oe,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output logic                       busy,
    output logic                       timeout_err,
    input  logic                       err_clr
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int ICW = $clog2(IDLE_CYCLES + 1);
    localparam logic [ICW-1:0] C_IDLE_MAX = ICW'(IDLE_CYCLES);
    localparam logic [31:0]    C_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [IDW:0]   C_NREQ     = (IDW + 1)'(NUM_REQ);

    if (NUM_REQ < 2 || IDLE_CYCLES < 1 || TIMEOUT_CYCLES < 2 || HALF_PERIOD < 1) begin : g_bad_params
        $error("i2c_bus_arbiter: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t               state_q;
    logic [1:0]           scl_sync_q, sda_sync_q;
    logic                 scl_s, sda_s, bus_idle;
    logic [ICW-1:0]       idle_cnt_q;
    logic                 hold_idle_q;
    logic [NUM_REQ-1:0]   mask_q, eligible, gnt_q;
    logic [IDW-1:0]       ptr_q, owner_q, pick_idx;
    logic [IDW:0]         cand;
    logic                 pick_found;
    logic                 busy_q, terr_q;
    logic [31:0]          tmo_cnt_q;
    logic                 own_scl, own_sda;

`ifdef I2C_BUS_RECOVERY_EN
    localparam int RCW = $clog2(HALF_PERIOD + 1);
    localparam logic [RCW-1:0] C_HP_LAST = RCW'(HALF_PERIOD - 1);
    typedef enum logic [2:0] {
        RP_LO    = 3'd0,
        RP_HI    = 3'd1,
        RP_STOP0 = 3'd2,
        RP_STOP1 = 3'd3,
        RP_STOP2 = 3'd4
    } rphase_t;
    rphase_t        rphase_q;
    logic [RCW-1:0] rcnt_q;
    logic [3:0]     pulses_q;
    logic           rec_scl_q, rec_sda_q;
`endif

    assign scl_s    = scl_sync_q[1];
    assign sda_s    = sda_sync_q[1];
    assign bus_idle = (idle_cnt_q == C_IDLE_MAX);
    assign eligible = req & ~mask_q;

    // First eligible requester at or after the round-robin pointer, with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW + 1)'(k);
            if (cand >= C_NREQ) cand = cand - C_NREQ;
            if (!pick_found && eligible[cand[IDW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDW-1:0];
            end
        end
    end

    assign own_scl = req_scl_oe[owner_q] & gnt_q[owner_q];
    assign own_sda = req_sda_oe[owner_q] & gnt_q[owner_q];
`ifdef I2C_BUS_RECOVERY_EN
    assign bus_scl_oe = own_scl | rec_scl_q;
    assign bus_sda_oe = own_sda | rec_sda_q;
`else
    assign bus_scl_oe = own_scl;
    assign bus_sda_oe = own_sda;
`endif

    assign gnt         = gnt_q;
    assign owner_id    = owner_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;

    always_ff @(posedge clk_100_clk) begin
        if (reset_100_reset) begin
            state_q     <= ST_IDLE;
            scl_sync_q  <= '0;
            sda_sync_q  <= '0;
            idle_cnt_q  <= '0;
            hold_idle_q <= 1'b0;
            mask_q      <= '0;
            gnt_q       <= '0;
            ptr_q       <= '0;
            owner_q     <= '0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
            tmo_cnt_q   <= '0;
`ifdef I2C_BUS_RECOVERY_EN
            rphase_q    <= RP_LO;
            rcnt_q      <= '0;
            pulses_q    <= '0;
            rec_scl_q   <= 1'b0;
            rec_sda_q   <= 1'b0;
`endif
        end else begin
            scl_sync_q  <= {scl_sync_q[0], bus_scl_in};
            sda_sync_q  <= {sda_sync_q[0], bus_sda_in};
            hold_idle_q <= (state_q != ST_IDLE);
            // Restart idle qualification for one extra cycle after leaving OWN
            // so the next owner always sees a full fresh idle window.
            if (state_q != ST_IDLE || hold_idle_q || !(scl_s && sda_s))
                idle_cnt_q <= '0;
            else if (idle_cnt_q != C_IDLE_MAX)
                idle_cnt_q <= idle_cnt_q + 1'b1;
            mask_q <= mask_q & req;
            if (err_clr) terr_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus_idle && pick_found) begin
                        gnt_q           <= '0;
                        gnt_q[pick_idx] <= 1'b1;
                        owner_q         <= pick_idx;
                        ptr_q           <= ({1'b0, pick_idx} == C_NREQ - 1'b1) ? '0 : pick_idx + 1'b1;
                        tmo_cnt_q       <= '0;
                        busy_q          <= 1'b1;
                        state_q         <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    if (!req[owner_q]) begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (tmo_cnt_q == C_TMO_LAST) begin
                        gnt_q           <= '0;
                        terr_q          <= 1'b1;
                        mask_q[owner_q] <= 1'b1;
`ifdef I2C_BUS_RECOVERY_EN
                        if (!sda_s) begin
                            rphase_q  <= RP_LO;
                            rcnt_q    <= '0;
                            pulses_q  <= '0;
                            rec_scl_q <= 1'b1;
                            rec_sda_q <= 1'b0;
                            state_q   <= ST_RECOVER;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
`else
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
`endif
                    end
                end
`ifdef I2C_BUS_RECOVERY_EN
                ST_RECOVER: begin
                    if (rcnt_q != C_HP_LAST) begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end else begin
                        rcnt_q <= '0;
                        case (rphase_q)
                            RP_LO: begin
                                rphase_q  <= RP_HI;
                                rec_scl_q <= 1'b0;
                                pulses_q  <= pulses_q + 1'b1;
                            end
                            RP_HI: begin
                                rec_scl_q <= 1'b1;
                                if (sda_s || pulses_q == 4'd9) begin
                                    rphase_q  <= RP_STOP0;
                                    rec_sda_q <= 1'b1;
                                end else begin
                                    rphase_q  <= RP_LO;
                                end
                            end
                            RP_STOP0: begin
                                rphase_q  <= RP_STOP1;
                                rec_scl_q <= 1'b0;
                            end
                            RP_STOP1: begin
                                rphase_q  <= RP_STOP2;
                                rec_sda_q <= 1'b0;
                            end
                            default: begin
                                rphase_q <= RP_LO;
                                busy_q   <= 1'b0;
                                state_q  <= ST_IDLE;
                            end
                        endcase
                    end
                end
`endif
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_arbiter
// Brief    : Directed self-checking bench for i2c_bus_arbiter (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_arbiter;
    localparam int NUM_REQ        = 2;
    localparam int IDLE_CYCLES    = 20;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int HALF_PERIOD    = 10;
    localparam int WAIT_BUDGET    = 4 * IDLE_CYCLES + 50;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_REQ-1:0] req, gnt, req_scl_oe, req_sda_oe;
    logic               bus_scl_in, bus_sda_in, bus_scl_oe, bus_sda_oe;
    logic               owner_id;
    logic               busy, timeout_err, err_clr;
    logic               ext_scl_low, ext_sda_low;
    int                 pass_cnt = 0;
    int                 total_cnt = 0;

    always #5 clk = ~clk;

    // Open-drain pads with pull-ups: low if the arbiter or an external agent pulls.
    assign bus_scl_in = ~(bus_scl_oe | ext_scl_low);
    assign bus_sda_in = ~(bus_sda_oe | ext_sda_low);

    i2c_bus_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .IDLE_CYCLES    (IDLE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .HALF_PERIOD    (HALF_PERIOD)
    ) dut (
        .clk_100_clk     (clk),
        .reset_100_reset (rst),
        .req             (req),
        .gnt             (gnt),
        .req_scl_oe      (req_scl_oe),
        .req_sda_oe      (req_sda_oe),
        .bus_scl_in      (bus_scl_in),
        .bus_sda_in      (bus_sda_in),
        .bus_scl_oe      (bus_scl_oe),
        .bus_sda_oe      (bus_sda_oe),
        .owner_id        (owner_id),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .err_clr         (err_clr)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_grant();
        for (int i = 0; i < WAIT_BUDGET; i++) begin
            if (gnt != '0) break;
            tick(1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_scl_oe = '0; req_sda_oe = '0;
        err_clr = 1'b0; ext_scl_low = 1'b0; ext_sda_low = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; req_scl_oe = '0; req_sda_oe = '0;
        err_clr = 1'b0; ext_scl_low = 1'b0; ext_sda_low = 1'b0;
        tick(2);
        total_cnt++;
        if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b required 00", gnt); else pass_cnt++;
        total_cnt++;
        if ({bus_scl_oe, bus_sda_oe} !== 2'b00) $display("FAIL reset_pads: got %b required 00", {bus_scl_oe, bus_sda_oe}); else pass_cnt++;
        total_cnt++;
        if ({owner_id, busy, timeout_err} !== 3'b000) $display("FAIL reset_status: owner/busy/err got %b required 000", {owner_id, busy, timeout_err}); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_grant_mux();
        tick(IDLE_CYCLES + 5);
        req_sda_oe = 2'b10; req_scl_oe = 2'b10;
        req = 2'b01;
        tick(1);
        total_cnt++;
        if ({gnt, owner_id, busy} !== 4'b0101) $display("FAIL grant_latency: gnt/owner/busy got %b required 0101", {gnt, owner_id, busy}); else pass_cnt++;
        total_cnt++;
        if ({bus_scl_oe, bus_sda_oe} !== 2'b00) $display("FAIL foreign_oe: pads got %b required 00", {bus_scl_oe, bus_sda_oe}); else pass_cnt++;
        req_sda_oe = 2'b11; #1;
        total_cnt++;
        if ({bus_scl_oe, bus_sda_oe} !== 2'b01) $display("FAIL owner_sda_on: pads got %b required 01", {bus_scl_oe, bus_sda_oe}); else pass_cnt++;
        req_sda_oe = 2'b10; #1;
        total_cnt++;
        if (bus_sda_oe !== 1'b0) $display("FAIL owner_sda_off: got %b required 0", bus_sda_oe); else pass_cnt++;
        req_sda_oe = 2'b11; req_scl_oe = 2'b11; #1;
        total_cnt++;
        if ({bus_scl_oe, bus_sda_oe} !== 2'b11) $display("FAIL owner_both_on: pads got %b required 11", {bus_scl_oe, bus_sda_oe}); else pass_cnt++;
        req = 2'b00;
        tick(1);
        total_cnt++;
        if ({gnt, busy, bus_scl_oe, bus_sda_oe} !== 5'b00000) $display("FAIL release_pads: gnt/busy/pads got %b required 00000", {gnt, busy, bus_scl_oe, bus_sda_oe}); else pass_cnt++;
        req_scl_oe = '0; req_sda_oe = '0;
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 2'b11;
        wait_grant();
        total_cnt++;
        if (gnt !== 2'b01) $display("FAIL rr_first: got %b required 01", gnt); else pass_cnt++;
        req = 2'b10;
        tick(1);
        total_cnt++;
        if (gnt !== 2'b00) $display("FAIL rr_release: got %b required 00", gnt); else pass_cnt++;
        tick(IDLE_CYCLES + 1);
        total_cnt++;
        if (gnt !== 2'b00) $display("FAIL rr_gap: got %b required 00", gnt); else pass_cnt++;
        tick(1);
        total_cnt++;
        if ({gnt, owner_id} !== 3'b101) $display("FAIL rr_second: gnt/owner got %b required 101", {gnt, owner_id}); else pass_cnt++;
        req = 2'b00;
        tick(1);
        req = 2'b11;
        wait_grant();
        total_cnt++;
        if (gnt !== 2'b01) $display("FAIL rr_wrap: got %b required 01", gnt); else pass_cnt++;
        req = 2'b00;
        tick(1);
    endtask

    task automatic test_sda_stuck();
        tick(2);
        ext_sda_low = 1'b1;
        req = 2'b01;
        tick(1000);
        total_cnt++;
        if (gnt !== 2'b00) $display("FAIL stuck_no_grant: got %b required 00", gnt); else pass_cnt++;
        ext_sda_low = 1'b0;
        tick(IDLE_CYCLES + 2);
        total_cnt++;
        if (gnt !== 2'b00) $display("FAIL stuck_gap: got %b required 00", gnt); else pass_cnt++;
        tick(1);
        total_cnt++;
        if (gnt !== 2'b01) $display("FAIL stuck_grant: got %b required 01", gnt); else pass_cnt++;
        req = 2'b00;
        tick(1);
    endtask

    task automatic test_timeout();
        do_reset();
        req = 2'b11;
        wait_grant();
        total_cnt++;
        if (gnt !== 2'b01) $display("FAIL tmo_grant: got %b required 01", gnt); else pass_cnt++;
        tick(TIMEOUT_CYCLES - 1);
        total_cnt++;
        if ({gnt, timeout_err} !== 3'b010) $display("FAIL tmo_before: gnt/err got %b required 010", {gnt, timeout_err}); else pass_cnt++;
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        total_cnt++;
        if (gnt !== 2'b00) $display("FAIL tmo_revoke: got %b required 00", gnt); else pass_cnt++;
        total_cnt++;
        if (timeout_err !== 1'b1) $display("FAIL tmo_set_priority: got %b required 1", timeout_err); else pass_cnt++;
        tick(IDLE_CYCLES + 1);
        total_cnt++;
        if (gnt !== 2'b00) $display("FAIL tmo_gap: got %b required 00", gnt); else pass_cnt++;
        tick(1);
        total_cnt++;
        if (gnt !== 2'b10) $display("FAIL tmo_next_owner: got %b required 10", gnt); else pass_cnt++;
        req = 2'b01;
        tick(1);
        tick(IDLE_CYCLES + 10);
        total_cnt++;
        if (gnt !== 2'b00) $display("FAIL tmo_masked: got %b required 00", gnt); else pass_cnt++;
        total_cnt++;
        if (timeout_err !== 1'b1) $display("FAIL tmo_sticky: got %b required 1", timeout_err); else pass_cnt++;
        req = 2'b00;
        tick(1);
        req = 2'b01;
        wait_grant();
        total_cnt++;
        if (gnt !== 2'b01) $display("FAIL tmo_unmask: got %b required 01", gnt); else pass_cnt++;
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        total_cnt++;
        if (timeout_err !== 1'b0) $display("FAIL err_clr: got %b required 0", timeout_err); else pass_cnt++;
        req = 2'b00;
        tick(1);
    endtask

    task automatic test_reset_mid_own();
        do_reset();
        req = 2'b01;
        wait_grant();
        req_sda_oe = 2'b01; #1;
        total_cnt++;
        if (bus_sda_oe !== 1'b1) $display("FAIL mid_pre_sda: got %b required 1", bus_sda_oe); else pass_cnt++;
        rst = 1'b1;
        tick(1);
        total_cnt++;
        if ({gnt, bus_scl_oe, bus_sda_oe} !== 4'b0000) $display("FAIL mid_reset_pads: gnt/pads got %b required 0000", {gnt, bus_scl_oe, bus_sda_oe}); else pass_cnt++;
        total_cnt++;
        if ({owner_id, busy, timeout_err} !== 3'b000) $display("FAIL mid_reset_status: got %b required 000", {owner_id, busy, timeout_err}); else pass_cnt++;
        rst = 1'b0;
        req_sda_oe = '0;
        req = 2'b11;
        wait_grant();
        total_cnt++;
        if (gnt !== 2'b01) $display("FAIL ptr_restart: got %b required 01", gnt); else pass_cnt++;
        req = 2'b00;
        tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_grant_mux();
        test_round_robin();
        test_sda_stuck();
        test_timeout();
        test_reset_mid_own();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
